// File: rtl/alias_decimator_if.sv
// Bundle of the alias_decimator control, FIFO handshake and sample bus.
// The master modport drives the stage; the slave modport is the stage itself.
interface alias_decimator_if #(
   parameter int DATA_W   = 32,
   parameter int MAX_LOG2 = 3,
   parameter int SEL_W    = 2
);
   logic [SEL_W-1:0]    ratio_sel;
   logic                hold_mode;
   logic [DATA_W-1:0]   left_channel_audio_in;
   logic [DATA_W-1:0]   right_channel_audio_in;
   logic                audio_in_available;
   logic                audio_out_allowed;
   logic                read_audio_in;
   logic                write_audio_out;
   logic [DATA_W-1:0]   left_channel_audio_out;
   logic [DATA_W-1:0]   right_channel_audio_out;
   logic [MAX_LOG2-1:0] phase;

   modport master (
      output ratio_sel,
      output hold_mode,
      output left_channel_audio_in,
      output right_channel_audio_in,
      output audio_in_available,
      output audio_out_allowed,
      input  read_audio_in,
      input  write_audio_out,
      input  left_channel_audio_out,
      input  right_channel_audio_out,
      input  phase
   );

   modport slave (
      input  ratio_sel,
      input  hold_mode,
      input  left_channel_audio_in,
      input  right_channel_audio_in,
      input  audio_in_available,
      input  audio_out_allowed,
      output read_audio_in,
      output write_audio_out,
      output left_channel_audio_out,
      output right_channel_audio_out,
      output phase
   );
endinterface

// File: rtl/alias_decimator.sv
// alias_decimator: keeps 1 of every 2^k stereo pairs, zero-stuffs or holds the rest.
// Ports: clk, reset (sync, active-high), bus (alias_decimator_if.slave).
// Optional: define ALIAS_DECIM_AVG_EN for a boxcar anti-alias filter on kept samples.
module alias_decimator #(
   parameter int DATA_W   = 32,
   parameter int MAX_LOG2 = 3,
   parameter int SEL_W    = 2
) (
   input  logic             clk,
   input  logic             reset,
   alias_decimator_if.slave bus
);
   typedef enum logic {EMPTY, FULL} state_t;

   localparam logic [SEL_W-1:0] K_MAX = SEL_W'(MAX_LOG2);

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    k_q, k_d;
   logic [MAX_LOG2-1:0] phase_q, phase_d;
   logic [MAX_LOG2-1:0] phase_mask;
   logic [DATA_W-1:0]   left_q, left_d;
   logic [DATA_W-1:0]   right_q, right_d;
   logic [DATA_W-1:0]   hold_l_q, hold_l_d;
   logic [DATA_W-1:0]   hold_r_q, hold_r_d;
   logic                obuf_v, rd, wr;
   logic                keep, k_chg;
   logic [DATA_W-1:0]   kept_l, kept_r;

   assign k_d   = (bus.ratio_sel > K_MAX) ? K_MAX : bus.ratio_sel;
   assign k_chg = (k_d != k_q);
   // Low k bits set: phase wraps at 2^k, k = 0 pins it to 0.
   assign phase_mask = ~({MAX_LOG2{1'b1}} << k_q);
   assign keep = (phase_q == '0);

`ifdef ALIAS_DECIM_AVG_EN
   localparam int ACC_W = DATA_W + MAX_LOG2;

   logic [ACC_W-1:0] acc_l_q, acc_l_d;
   logic [ACC_W-1:0] acc_r_q, acc_r_d;
   logic             first_q, first_d;
   logic [ACC_W-1:0] in_l_x, in_r_x;

   assign in_l_x = {{MAX_LOG2{bus.left_channel_audio_in[DATA_W-1]}},
                    bus.left_channel_audio_in};
   assign in_r_x = {{MAX_LOG2{bus.right_channel_audio_in[DATA_W-1]}},
                    bus.right_channel_audio_in};

   always_comb begin
      kept_l  = bus.left_channel_audio_in;
      kept_r  = bus.right_channel_audio_in;
      acc_l_d = acc_l_q;
      acc_r_d = acc_r_q;
      first_d = first_q;
      // No complete block behind us yet, or bypass: pass raw input.
      if (k_q != '0 && !first_q) begin
         kept_l = DATA_W'($signed(acc_l_q) >>> k_q);
         kept_r = DATA_W'($signed(acc_r_q) >>> k_q);
      end
      if (rd) begin
         if (keep) begin
            acc_l_d = in_l_x;
            acc_r_d = in_r_x;
            first_d = 1'b0;
         end else begin
            acc_l_d = acc_l_q + in_l_x;
            acc_r_d = acc_r_q + in_r_x;
         end
      end
      // Block boundary moves on a ratio change; the partial sum is stale.
      if (k_chg) first_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_l_q <= '0;
         acc_r_q <= '0;
         first_q <= 1'b1;
      end else begin
         acc_l_q <= acc_l_d;
         acc_r_q <= acc_r_d;
         first_q <= first_d;
      end
   end
`else
   assign kept_l = bus.left_channel_audio_in;
   assign kept_r = bus.right_channel_audio_in;
`endif

   always_comb begin
      obuf_v   = (state_q == FULL);
      wr       = obuf_v & bus.audio_out_allowed;
      rd       = bus.audio_in_available & (~obuf_v | wr);
      state_d  = state_q;
      phase_d  = phase_q;
      left_d   = left_q;
      right_d  = right_q;
      hold_l_d = hold_l_q;
      hold_r_d = hold_r_q;

      unique case (state_q)
         EMPTY: if (rd) state_d = FULL;
         FULL:  if (!rd && wr) state_d = EMPTY;
      endcase

      if (rd) begin
         if (keep) begin
            left_d   = kept_l;
            right_d  = kept_r;
            hold_l_d = kept_l;
            hold_r_d = kept_r;
         end else if (bus.hold_mode) begin
            left_d   = hold_l_q;
            right_d  = hold_r_q;
         end else begin
            left_d   = '0;
            right_d  = '0;
         end
      end

      // A ratio change realigns so the next accepted pair is kept.
      if (k_chg) begin
         phase_d = '0;
      end else if (rd) begin
         phase_d = (phase_q + MAX_LOG2'(1)) & phase_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= EMPTY;
         k_q      <= '0;
         phase_q  <= '0;
         left_q   <= '0;
         right_q  <= '0;
         hold_l_q <= '0;
         hold_r_q <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         phase_q  <= phase_d;
         left_q   <= left_d;
         right_q  <= right_d;
         hold_l_q <= hold_l_d;
         hold_r_q <= hold_r_d;
      end
   end

   assign bus.read_audio_in           = rd;
   assign bus.write_audio_out         = wr;
   assign bus.left_channel_audio_out  = left_q;
   assign bus.right_channel_audio_out = right_q;
   assign bus.phase                   = phase_q;
endmodule

// File: tb/tb_alias_decimator.sv
// Testbench for alias_decimator: scoreboard of expected output pairs
// plus directed scenarios and a randomised back-to-back run.
module tb_alias_decimator;
   localparam int DW = 32;
   localparam int ML = 3;
   localparam int SW = 2;

   typedef struct packed {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
   } pair_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   alias_decimator_if #(.DATA_W(DW), .MAX_LOG2(ML), .SEL_W(SW)) bus ();

   alias_decimator #(.DATA_W(DW), .MAX_LOG2(ML), .SEL_W(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   pair_t         stim_q[$];
   pair_t         exp_q[$];
   logic [DW-1:0] got_l[$];
   int total = 0;
   int bad = 0;
   int rd_cnt = 0;
   logic [SW-1:0] nx_ratio = '0;
   logic          nx_hold = 1'b0;

   // reference model state
   bit            m_obuf;
   int            m_phase;
   int            m_k;
   bit            m_first;
   logic [DW-1:0] m_hl, m_hr;
   longint        m_sum_l, m_sum_r;

   function automatic int clampk(input int s);
      return (s > ML) ? ML : s;
   endfunction

   task automatic push_in(input logic [DW-1:0] v);
      pair_t p;
      p.l = v;
      p.r = ~v;
      stim_q.push_back(p);
   endtask

   task automatic step(input bit avail, input bit allowed);
      bit av, erd, ewr, wr, rd;
      pair_t e, p;
      int nk;
      @(negedge clk);
      av = avail && (stim_q.size() > 0);
      bus.ratio_sel = nx_ratio;
      bus.hold_mode = nx_hold;
      bus.audio_in_available = av;
      bus.audio_out_allowed = allowed;
      if (stim_q.size() > 0) begin
         bus.left_channel_audio_in = stim_q[0].l;
         bus.right_channel_audio_in = stim_q[0].r;
      end
      #1;
      ewr = m_obuf && allowed;
      erd = av && (!m_obuf || ewr);
      wr = bus.write_audio_out;
      rd = bus.read_audio_in;
      total++;
      if (wr !== ewr) begin
         bad++;
         $display("FAIL write: got %b want %b", wr, ewr);
      end
      total++;
      if (rd !== erd) begin
         bad++;
         $display("FAIL read: got %b want %b", rd, erd);
      end
      total++;
      if (bus.phase !== ML'(m_phase)) begin
         bad++;
         $display("FAIL phase: got %0d want %0d", bus.phase, m_phase);
      end
      if (m_obuf) begin
         total++;
         if (bus.left_channel_audio_out !== exp_q[0].l ||
             bus.right_channel_audio_out !== exp_q[0].r) begin
            bad++;
            $display("FAIL data: got %h/%h want %h/%h",
                     bus.left_channel_audio_out, bus.right_channel_audio_out,
                     exp_q[0].l, exp_q[0].r);
         end
         if (ewr) begin
            got_l.push_back(bus.left_channel_audio_out);
            void'(exp_q.pop_front());
         end
      end
      if (erd) begin
         rd_cnt++;
         p = stim_q.pop_front();
         if (m_phase == 0) begin
            e = p;
`ifdef ALIAS_DECIM_AVG_EN
            if (m_k != 0 && !m_first) begin
               e.l = DW'(m_sum_l >>> m_k);
               e.r = DW'(m_sum_r >>> m_k);
            end
            m_sum_l = longint'($signed(p.l));
            m_sum_r = longint'($signed(p.r));
            m_first = 1'b0;
`endif
            m_hl = e.l;
            m_hr = e.r;
         end else begin
            e.l = nx_hold ? m_hl : '0;
            e.r = nx_hold ? m_hr : '0;
`ifdef ALIAS_DECIM_AVG_EN
            m_sum_l += longint'($signed(p.l));
            m_sum_r += longint'($signed(p.r));
`endif
         end
         exp_q.push_back(e);
      end
      m_obuf = erd ? 1'b1 : (ewr ? 1'b0 : m_obuf);
      nk = clampk(int'(nx_ratio));
      if (nk != m_k) begin
         m_k = nk;
         m_phase = 0;
         m_first = 1'b1;
      end else if (erd) begin
         m_phase = (m_phase + 1) % (1 << m_k);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.ratio_sel = nx_ratio;
      bus.hold_mode = nx_hold;
      bus.audio_in_available = 1'b1;
      bus.audio_out_allowed = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      bus.audio_in_available = 1'b0;
      bus.audio_out_allowed = 1'b1;
      #1;
      total++;
      if (bus.left_channel_audio_out !== '0) begin
         bad++;
         $display("FAIL rst_left: got %h want 0", bus.left_channel_audio_out);
      end
      total++;
      if (bus.right_channel_audio_out !== '0) begin
         bad++;
         $display("FAIL rst_right: got %h want 0", bus.right_channel_audio_out);
      end
      total++;
      if (bus.write_audio_out !== 1'b0) begin
         bad++;
         $display("FAIL rst_write: got %b want 0", bus.write_audio_out);
      end
      total++;
      if (bus.phase !== '0) begin
         bad++;
         $display("FAIL rst_phase: got %0d want 0", bus.phase);
      end
      m_obuf = 1'b0;
      m_phase = 0;
      m_k = clampk(int'(nx_ratio));
      m_first = 1'b1;
      m_hl = '0;
      m_hr = '0;
      m_sum_l = 0;
      m_sum_r = 0;
      exp_q.delete();
      stim_q.delete();
      got_l.delete();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 32) begin
         step(1'b0, 1'b1);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d pairs left want 0", exp_q.size());
      end
   endtask

   task automatic check_got(input string nm, input int idx, input logic [DW-1:0] want);
      total++;
      if (idx >= got_l.size()) begin
         bad++;
         $display("FAIL %s[%0d]: got none want %0d", nm, idx, $signed(want));
      end else if (got_l[idx] !== want) begin
         bad++;
         $display("FAIL %s[%0d]: got %0d want %0d", nm, idx,
                  $signed(got_l[idx]), $signed(want));
      end
   endtask

   task automatic test_reset();
      nx_ratio = 2'd2;
      nx_hold = 1'b0;
      apply_reset();
      step(1'b0, 1'b1);
      push_in(32'd5);
      push_in(32'd6);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      apply_reset();
      step(1'b0, 1'b1);
   endtask

   task automatic test_zero_stuff();
      logic [DW-1:0] want [4] = '{32'd1, 32'd0, 32'd3, 32'd0};
      nx_ratio = 2'd1;
      nx_hold = 1'b0;
      apply_reset();
      step(1'b0, 1'b1);
      got_l.delete();
      rd_cnt = 0;
      for (int i = 1; i <= 4; i++) push_in(DW'(i));
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
      total++;
      if (rd_cnt != 4) begin
         bad++;
         $display("FAIL zs_reads: got %0d want 4", rd_cnt);
      end
      step(1'b1, 1'b1);
      total++;
      if (got_l.size() != 4) begin
         bad++;
         $display("FAIL zs_writes: got %0d want 4", got_l.size());
      end
      for (int i = 0; i < 4; i++) check_got("zs", i, want[i]);
   endtask

   task automatic test_hold();
      logic [DW-1:0] want [8] = '{32'd10, 32'd10, 32'd10, 32'd10,
                                  32'd14, 32'd14, 32'd14, 32'd14};
      nx_ratio = 2'd2;
      nx_hold = 1'b1;
      apply_reset();
      step(1'b0, 1'b1);
      got_l.delete();
      for (int i = 10; i <= 17; i++) push_in(DW'(i));
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1);
      drain();
      for (int i = 0; i < 8; i++) check_got("hold", i, want[i]);
   endtask

   task automatic test_stall();
      nx_ratio = 2'd3;
      nx_hold = 1'b0;
      apply_reset();
      step(1'b0, 1'b1);
      got_l.delete();
      for (int i = 20; i <= 28; i++) push_in(DW'(i));
      rd_cnt = 0;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      total++;
      if (rd_cnt != 1) begin
         bad++;
         $display("FAIL stall_reads: got %0d want 1", rd_cnt);
      end
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
      drain();
      check_got("stall", 0, 32'd20);
      for (int i = 1; i < 8; i++) check_got("stall", i, 32'd0);
      check_got("stall", 8, 32'd28);
   endtask

   task automatic test_ratio_change();
      nx_ratio = 2'd2;
      nx_hold = 1'b0;
      apply_reset();
      step(1'b0, 1'b1);
      got_l.delete();
      push_in(32'd30);
      push_in(32'd31);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      nx_ratio = 2'd1;
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      total++;
      if (bus.phase !== '0) begin
         bad++;
         $display("FAIL rc_phase: got %0d want 0", bus.phase);
      end
      push_in(32'd55);
      step(1'b1, 1'b1);
      drain();
      check_got("rc", 2, 32'd55);
   endtask

`ifdef ALIAS_DECIM_AVG_EN
   task automatic test_avg();
      int v [13] = '{4, 8, -4, 0, 7, 1, 1, 1, -8, -8, -8, -1, 5};
      nx_ratio = 2'd2;
      nx_hold = 1'b0;
      apply_reset();
      step(1'b0, 1'b1);
      got_l.delete();
      foreach (v[i]) push_in(DW'(v[i]));
      for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
      drain();
      check_got("avg", 0, 32'd4);
      check_got("avg", 4, 32'd2);
      check_got("avg", 8, 32'd2);
      check_got("avg", 12, 32'hFFFF_FFF9);
   endtask
`endif

   task automatic test_back_to_back();
      nx_ratio = 2'd2;
      nx_hold = 1'b0;
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) nx_ratio = SW'($urandom_range(0, 3));
         nx_hold = 1'($urandom_range(0, 1));
         if (stim_q.size() < 4) push_in(DW'($urandom));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end
      drain();
   endtask

   initial begin
      bus.ratio_sel = '0;
      bus.hold_mode = 1'b0;
      bus.left_channel_audio_in = '0;
      bus.right_channel_audio_in = '0;
      bus.audio_in_available = 1'b0;
      bus.audio_out_allowed = 1'b0;
      test_reset();
      test_zero_stuff();
      test_hold();
      test_stall();
      test_ratio_change();
`ifdef ALIAS_DECIM_AVG_EN
      test_avg();
`endif
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
